demux4_stream_sched: RTL and testbench

//  Sequences a shared 1-to-4 demultiplexer datapath for a valid/ready byte stream.
//  - Accepts one word per transfer on a single input port.
//  - Picks a destination channel (round-robin or tagged), drives the demux select
//    and holds the word until that channel accepts it.
//  - Sits between an upstream producer and four downstream consumers.
//  - Sustains 1 word/cycle when the chosen consumer is ready.

---
 rtl/demux4_stream_sched_pkg.sv | 20 ++
 rtl/demux4_stream_sched_if.sv | 27 ++
 rtl/demux4_stream_sched_onehot.sv | 15 +
 rtl/demux4_stream_sched.sv | 108 ++++++++++
 tb/tb_demux4_stream_sched.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/demux4_stream_sched_pkg.sv
// Shared definitions for the demux4_stream_sched block: channel count,
// FSM state encoding, destination modes and the round-robin step helper.
package demux4_stream_sched_pkg;

   localparam int N_CH = 4;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   localparam logic MODE_RR   = 1'b0;
   localparam logic MODE_DEST = 1'b1;

   // Next round-robin channel; 2-bit arithmetic gives the 3 -> 0 wrap.
   function automatic logic [1:0] next_ch(input logic [1:0] ch);
      return ch + 2'd1;
   endfunction

endpackage

// File: rtl/demux4_stream_sched_if.sv
// Stream-side signals of demux4_stream_sched: upstream valid/ready word,
// destination control, and the shared 1-to-4 downstream bus.
// slave = the scheduler, master = the producer/consumer environment.
interface demux4_stream_sched_if #(
   parameter int DATA_W = 8
);
   logic              mode;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic [1:0]        in_dest;
   logic              in_ready;
   logic [3:0]        out_valid;
   logic [DATA_W-1:0] out_data;
   logic [3:0]        out_ready;
   logic [1:0]        sel;
   logic              busy;

   modport slave (
      input  mode, in_valid, in_data, in_dest, out_ready,
      output in_ready, out_valid, out_data, sel, busy
   );

   modport master (
      output mode, in_valid, in_data, in_dest, out_ready,
      input  in_ready, out_valid, out_data, sel, busy
   );
endinterface

// File: rtl/demux4_stream_sched_onehot.sv
// demux_onehot4: enable-gated 2-to-4 one-hot decoder. Used for the
// per-channel out_valid and for the per-channel counter increment enable.
module demux_onehot4 (
   input  logic       en,
   input  logic [1:0] idx,
   output logic [3:0] onehot
);

   // Decode idx to a single set bit, all zero when disabled.
   always_comb begin
      onehot = '0;
      if (en) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/demux4_stream_sched.sv
// demux4_stream_sched: single-entry scheduler for a shared 1-to-4 demux.
// Holds one word, steers it to a round-robin or tagged channel, and
// releases it when that channel is ready. Back-to-back transfers run at
// one word per cycle because in_ready passes out_ready[sel] straight through.
// Optional per-channel drain counters: define DEMUX_SCHED_STATS_EN.
//
//  state    | meaning
//  ---------+------------------------------------------------
//  ST_EMPTY | no word held, in_ready=1
//  ST_FULL  | word held for channel sel, waiting for out_ready[sel]
import demux4_stream_sched_pkg::*;

module demux4_stream_sched #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   demux4_stream_sched_if.slave   bus
`ifdef DEMUX_SCHED_STATS_EN
   ,
   input  logic                   stats_clr,
   output logic [4*CNT_W-1:0]     stats_cnt
`endif
);

   state_t            state;
   logic [DATA_W-1:0] data_q;
   logic [1:0]        sel_q;
   logic [1:0]        rr_ptr;
   logic              busy;
   logic              in_ready;
   logic              accept;
   logic              drain;
   logic [1:0]        dest_d;
   logic [3:0]        valid_oh;

   assign busy     = (state == ST_FULL);
   assign in_ready = !busy || bus.out_ready[sel_q];
   assign accept   = bus.in_valid && in_ready;
   assign drain    = busy && bus.out_ready[sel_q];
   assign dest_d   = (bus.mode == MODE_RR) ? rr_ptr : bus.in_dest;

   // Sequencer: state, held word, its channel and the round-robin pointer.
   // In FULL an accept can only happen together with a drain, so FULL
   // stays FULL on accept and falls to EMPTY only on a bare drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_EMPTY;
         data_q <= '0;
         sel_q  <= '0;
         rr_ptr <= '0;
      end else begin
         if (accept) begin
            data_q <= bus.in_data;
            sel_q  <= dest_d;
            if (bus.mode == MODE_RR) rr_ptr <= next_ch(rr_ptr);
         end
         case (state)
            ST_EMPTY: if (accept) state <= ST_FULL;
            ST_FULL:  if (drain && !accept) state <= ST_EMPTY;
            default:  state <= ST_EMPTY;
         endcase
      end
   end

   demux_onehot4 u_valid_dec (
      .en     (busy),
      .idx    (sel_q),
      .onehot (valid_oh)
   );

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = valid_oh;
   assign bus.out_data  = data_q;
   assign bus.sel       = sel_q;
   assign bus.busy      = busy;

`ifdef DEMUX_SCHED_STATS_EN
   logic [3:0]       inc_oh;
   logic [CNT_W-1:0] cnt [N_CH];

   demux_onehot4 u_inc_dec (
      .en     (drain),
      .idx    (sel_q),
      .onehot (inc_oh)
   );

   // Saturating drain counters; a clear wins over a same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
      end else if (stats_clr) begin
         for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
      end else begin
         for (int k = 0; k < N_CH; k++)
            if (inc_oh[k] && (cnt[k] != {CNT_W{1'b1}})) cnt[k] <= cnt[k] + 1'b1;
      end
   end

   // Flatten the counters onto the packed statistics bus.
   always_comb begin
      stats_cnt = '0;
      for (int k = 0; k < N_CH; k++) stats_cnt[k*CNT_W +: CNT_W] = cnt[k];
   end
`endif

endmodule

// File: tb/tb_demux4_stream_sched.sv
// Directed bench for demux4_stream_sched: async reset mid-transfer, a
// cycle-by-cycle vector table (round-robin, stalled tagged word, destination
// change while full) and, with DEMUX_SCHED_STATS_EN, counter saturate/clear.
module tb_demux4_stream_sched;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   demux4_stream_sched_if #(.DATA_W(DATA_W)) bus_if ();

`ifdef DEMUX_SCHED_STATS_EN
   logic               stats_clr;
   logic [4*CNT_W-1:0] stats_cnt;
`endif

   demux4_stream_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_if)
`ifdef DEMUX_SCHED_STATS_EN
      ,
      .stats_clr (stats_clr),
      .stats_cnt (stats_cnt)
`endif
   );

   typedef struct {
      logic       mode;
      logic       vld;
      logic [7:0] data;
      logic [1:0] dest;
      logic [3:0] rdy;
      logic       e_ir;
      logic [3:0] e_ov;
      logic [7:0] e_data;
      logic [1:0] e_sel;
      logic       e_busy;
   } vec_t;

   vec_t vecs [26];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic drive(input logic m, input logic v, input logic [7:0] d,
                        input logic [1:0] ds, input logic [3:0] r);
      bus_if.mode      = m;
      bus_if.in_valid  = v;
      bus_if.in_data   = d;
      bus_if.in_dest   = ds;
      bus_if.out_ready = r;
   endtask

   initial begin
      // mode vld data dest rdy | in_ready out_valid out_data sel busy
      vecs[0]  = '{1'b0, 1'b1, 8'hA0, 2'd0, 4'hF, 1'b1, 4'h0, 8'h00, 2'd0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 8'hA1, 2'd0, 4'hF, 1'b1, 4'h1, 8'hA0, 2'd0, 1'b1};
      vecs[2]  = '{1'b0, 1'b1, 8'hA2, 2'd0, 4'hF, 1'b1, 4'h2, 8'hA1, 2'd1, 1'b1};
      vecs[3]  = '{1'b0, 1'b1, 8'hA3, 2'd0, 4'hF, 1'b1, 4'h4, 8'hA2, 2'd2, 1'b1};
      vecs[4]  = '{1'b0, 1'b1, 8'hA4, 2'd0, 4'hF, 1'b1, 4'h8, 8'hA3, 2'd3, 1'b1};
      vecs[5]  = '{1'b0, 1'b1, 8'hA5, 2'd0, 4'hF, 1'b1, 4'h1, 8'hA4, 2'd0, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 8'h00, 2'd0, 4'hF, 1'b1, 4'h2, 8'hA5, 2'd1, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 8'h00, 2'd0, 4'hF, 1'b1, 4'h0, 8'hA5, 2'd1, 1'b0};
      // tagged word to ch2, ch2 not ready for 5 cycles; a waiting word must not enter
      vecs[8]  = '{1'b1, 1'b1, 8'h5C, 2'd2, 4'hB, 1'b1, 4'h0, 8'hA5, 2'd1, 1'b0};
      for (int i = 9; i <= 13; i++)
         vecs[i] = '{1'b1, 1'b1, 8'h77, 2'd0, 4'hB, 1'b0, 4'h4, 8'h5C, 2'd2, 1'b1};
      vecs[14] = '{1'b1, 1'b1, 8'h77, 2'd0, 4'hF, 1'b1, 4'h4, 8'h5C, 2'd2, 1'b1};
      vecs[15] = '{1'b1, 1'b0, 8'h00, 2'd0, 4'hF, 1'b1, 4'h1, 8'h77, 2'd0, 1'b1};
      vecs[16] = '{1'b1, 1'b0, 8'h00, 2'd0, 4'hF, 1'b1, 4'h0, 8'h77, 2'd0, 1'b0};
      // word to ch3, in_dest flips to 0 while held; ch0 ready is ignored
      vecs[17] = '{1'b1, 1'b1, 8'hC3, 2'd3, 4'h0, 1'b1, 4'h0, 8'h77, 2'd0, 1'b0};
      vecs[18] = '{1'b1, 1'b0, 8'h00, 2'd0, 4'h0, 1'b0, 4'h8, 8'hC3, 2'd3, 1'b1};
      vecs[19] = '{1'b1, 1'b1, 8'hD0, 2'd0, 4'h1, 1'b0, 4'h8, 8'hC3, 2'd3, 1'b1};
      vecs[20] = '{1'b1, 1'b1, 8'hD0, 2'd0, 4'h8, 1'b1, 4'h8, 8'hC3, 2'd3, 1'b1};
      vecs[21] = '{1'b1, 1'b0, 8'h00, 2'd0, 4'h1, 1'b1, 4'h1, 8'hD0, 2'd0, 1'b1};
      vecs[22] = '{1'b1, 1'b0, 8'h00, 2'd0, 4'h0, 1'b1, 4'h0, 8'hD0, 2'd0, 1'b0};
      // back to round-robin: pointer held at 2 through the tagged traffic
      vecs[23] = '{1'b0, 1'b1, 8'hE2, 2'd0, 4'hF, 1'b1, 4'h0, 8'hD0, 2'd0, 1'b0};
      vecs[24] = '{1'b0, 1'b0, 8'h00, 2'd0, 4'hF, 1'b1, 4'h4, 8'hE2, 2'd2, 1'b1};
      vecs[25] = '{1'b0, 1'b0, 8'h00, 2'd0, 4'hF, 1'b1, 4'h0, 8'hE2, 2'd2, 1'b0};

      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 2'd0, 4'h0);
`ifdef DEMUX_SCHED_STATS_EN
      stats_clr = 1'b0;
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Async reset while a word is held for ch2
      @(negedge clk);
      drive(1'b1, 1'b1, 8'h42, 2'd2, 4'h0);
      @(negedge clk);
      drive(1'b1, 1'b0, 8'h00, 2'd0, 4'h0);
      #1;
      chk("pre_rst_out_valid", bus_if.out_valid, 4'b0100);
      chk("pre_rst_busy", bus_if.busy, 1'b1);
      chk("pre_rst_in_ready", bus_if.in_ready, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("rst_out_valid", bus_if.out_valid, 4'b0000);
      chk("rst_busy", bus_if.busy, 1'b0);
      chk("rst_sel", bus_if.sel, 2'd0);
      chk("rst_out_data", bus_if.out_data, 8'h00);
      chk("rst_in_ready", bus_if.in_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         drive(vecs[i].mode, vecs[i].vld, vecs[i].data, vecs[i].dest, vecs[i].rdy);
         #1;
         chk($sformatf("v%0d_in_ready", i), bus_if.in_ready, vecs[i].e_ir);
         chk($sformatf("v%0d_out_valid", i), bus_if.out_valid, vecs[i].e_ov);
         chk($sformatf("v%0d_out_data", i), bus_if.out_data, vecs[i].e_data);
         chk($sformatf("v%0d_sel", i), bus_if.sel, vecs[i].e_sel);
         chk($sformatf("v%0d_busy", i), bus_if.busy, vecs[i].e_busy);
      end

`ifdef DEMUX_SCHED_STATS_EN
      // Five drains to ch1 with 2-bit counters, then clear coincident with a drain
      @(negedge clk);
      rst = 1'b1;
      drive(1'b1, 1'b0, 8'h00, 2'd1, 4'hF);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         drive(1'b1, (k < 5), 8'(k), 2'd1, 4'hF);
         #1;
         chk($sformatf("cnt1_step%0d", k), stats_cnt[1*CNT_W +: CNT_W],
             (k < 1) ? 0 : ((k - 1 > 3) ? 3 : k - 1));
      end
      @(negedge clk);
      drive(1'b1, 1'b1, 8'h09, 2'd1, 4'hF);
      #1;
      chk("cnt1_saturated", stats_cnt[1*CNT_W +: CNT_W], 2'd3);
      chk("sat_busy", bus_if.busy, 1'b0);
      @(negedge clk);
      drive(1'b1, 1'b0, 8'h00, 2'd1, 4'hF);
      stats_clr = 1'b1;
      #1;
      chk("clr_drain_pending", bus_if.out_valid, 4'b0010);
      @(negedge clk);
      stats_clr = 1'b0;
      #1;
      chk("cnt1_after_clr", stats_cnt[1*CNT_W +: CNT_W], 2'd0);
      chk("cnt0_after_clr", stats_cnt[0 +: CNT_W], 2'd0);
      chk("cnt_all_after_clr", stats_cnt, 8'h00);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
